// File: rtl/ram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ram_ctrl_pkg
// Shared definitions for the RAM burst access controller.
//   - Default widths for the RAM address, RAM data and burst-length fields.
//   - FSM state enumeration used by ram_access_ctrl.
// -----------------------------------------------------------------------------
package ram_ctrl_pkg;

   // Default geometry: 16-word RAM of bytes, bursts of 1..16 beats.
   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 8;
   localparam int LEN_W_DEF  = 4;

   // Controller states.
   //   IDLE     : waiting for a burst request (REQ_READY high)
   //   WR_WAIT  : waiting for one write beat on WR_VALID
   //   WR_PULSE : one-cycle RAM write strobe for the captured beat
   //   RD_ADDR  : RAM address presented, RAM_DATA_OUT captured at cycle end
   //   RD_RESP  : read beat offered on RD_VALID until RD_READY
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_WAIT  = 3'd1,
      WR_PULSE = 3'd2,
      RD_ADDR  = 3'd3,
      RD_RESP  = 3'd4
   } state_e;

endpackage : ram_ctrl_pkg

// File: rtl/ram_burst_counter.sv
// -----------------------------------------------------------------------------
// ram_burst_counter
// Address and beat bookkeeping for one burst.
//   clk      : rising-edge clock
//   srst     : synchronous active-high reset (address and count cleared)
//   load_i   : start of burst; takes addr_i / len_i
//   step_i   : advance to the next beat (address +1, count -1)
//   addr_i   : burst start address
//   len_i    : beats minus one
//   addr_o   : current beat address (registered), wraps modulo 2^ADDR_W
//   last_o   : current beat is the final beat of the burst
// -----------------------------------------------------------------------------
module ram_burst_counter
   import ram_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_o
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  beats_q, beats_d;

   // Load takes priority over step; the controller never asserts both, but a
   // defined priority keeps the counter well behaved if it ever does.
   always_comb begin
      addr_d  = addr_q;
      beats_d = beats_q;
      if (load_i) begin
         addr_d  = addr_i;
         beats_d = len_i;
      end else if (step_i) begin
         // Plain ADDR_W-bit addition gives the required wrap to address 0.
         addr_d  = addr_q + ADDR_W'(1);
         beats_d = beats_q - LEN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         addr_q  <= '0;
         beats_q <= '0;
      end else begin
         addr_q  <= addr_d;
         beats_q <= beats_d;
      end
   end

   assign addr_o = addr_q;
   assign last_o = (beats_q == '0);

endmodule : ram_burst_counter

// File: rtl/ram_access_ctrl.sv
// -----------------------------------------------------------------------------
// ram_access_ctrl
// Burst front-end for a simple single-port RAM with a combinational read path
// and a one-cycle write strobe.
//
// Ports
//   CLK, RESET                 : clock, synchronous active-high reset
//   REQ_VALID/REQ_READY        : burst request handshake (READY only in IDLE)
//   REQ_WRITE, REQ_ADDR, REQ_LEN : direction, start address, beats minus one
//   WR_DATA, WR_VALID/WR_READY : write beat stream
//   RD_DATA, RD_VALID/RD_READY : read beat stream
//   BUSY                       : controller not in IDLE
//   RAM_ADDRESS, RAM_DATA_IN, RAM_OPCODE : registered RAM controls
//   RAM_DATA_OUT               : RAM read data (combinational from RAM_ADDRESS)
//
// Each beat takes at least two cycles: WR_WAIT+WR_PULSE for writes,
// RD_ADDR+RD_RESP for reads. The RAM address only advances when a beat is
// finished, so the address is stable across the whole write strobe.
// -----------------------------------------------------------------------------
module ram_access_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              CLK,
   input  logic              RESET,
   // request channel
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic              REQ_WRITE,
   input  logic [ADDR_W-1:0] REQ_ADDR,
   input  logic [LEN_W-1:0]  REQ_LEN,
   // write beat channel
   input  logic [DATA_W-1:0] WR_DATA,
   input  logic              WR_VALID,
   output logic              WR_READY,
   // read beat channel
   output logic [DATA_W-1:0] RD_DATA,
   output logic              RD_VALID,
   input  logic              RD_READY,
   // status
   output logic              BUSY,
   // RAM side
   output logic [ADDR_W-1:0] RAM_ADDRESS,
   output logic [DATA_W-1:0] RAM_DATA_IN,
   output logic              RAM_OPCODE,
   input  logic [DATA_W-1:0] RAM_DATA_OUT
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] data_in_q, data_in_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              opcode_q, opcode_d;

   logic              cnt_load;
   logic              cnt_step;
   logic [ADDR_W-1:0] cnt_addr;
   logic              cnt_last;

   ram_burst_counter #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_counter (
      .clk    (CLK),
      .srst   (RESET),
      .load_i (cnt_load),
      .step_i (cnt_step),
      .addr_i (REQ_ADDR),
      .len_i  (REQ_LEN),
      .addr_o (cnt_addr),
      .last_o (cnt_last)
   );

   // Next-state and datapath control.
   always_comb begin
      state_d   = state_q;
      data_in_d = data_in_q;
      rd_data_d = rd_data_q;
      cnt_load  = 1'b0;
      cnt_step  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (REQ_VALID) begin
               cnt_load = 1'b1;
               state_d  = REQ_WRITE ? WR_WAIT : RD_ADDR;
            end
         end
         WR_WAIT: begin
            if (WR_VALID) begin
               data_in_d = WR_DATA;
               state_d   = WR_PULSE;
            end
         end
         WR_PULSE: begin
            if (cnt_last) begin
               state_d = IDLE;
            end else begin
               cnt_step = 1'b1;
               state_d  = WR_WAIT;
            end
         end
         RD_ADDR: begin
            // RAM_ADDRESS has been valid for this whole cycle, so the
            // combinational RAM output is settled at the closing edge.
            rd_data_d = RAM_DATA_OUT;
            state_d   = RD_RESP;
         end
         RD_RESP: begin
            if (RD_READY) begin
               if (cnt_last) begin
                  state_d = IDLE;
               end else begin
                  cnt_step = 1'b1;
                  state_d  = RD_ADDR;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // The strobe register mirrors the state register, so RAM_OPCODE is high
      // exactly for the WR_PULSE cycle and no other.
      opcode_d = (state_d == WR_PULSE);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= IDLE;
         data_in_q <= '0;
         rd_data_q <= '0;
         opcode_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_in_q <= data_in_d;
         rd_data_q <= rd_data_d;
         opcode_q  <= opcode_d;
      end
   end

   // Handshake and status outputs decode directly from the state register.
   assign REQ_READY   = (state_q == IDLE);
   assign WR_READY    = (state_q == WR_WAIT);
   assign RD_VALID    = (state_q == RD_RESP);
   assign BUSY        = (state_q != IDLE);

   assign RD_DATA     = rd_data_q;
   assign RAM_ADDRESS = cnt_addr;
   assign RAM_DATA_IN = data_in_q;
   assign RAM_OPCODE  = opcode_q;

endmodule : ram_access_ctrl

// File: tb/tb_ram_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram_access_ctrl
// Directed bench for ram_access_ctrl with a behavioural 16x8 RAM attached.
// Expected RAM writes and read beats are queued when stimulus is driven and
// compared when the controller produces them.
// -----------------------------------------------------------------------------
module tb_ram_access_ctrl;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int LW = 4;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          REQ_VALID;
   logic          REQ_READY;
   logic          REQ_WRITE;
   logic [AW-1:0] REQ_ADDR;
   logic [LW-1:0] REQ_LEN;
   logic [DW-1:0] WR_DATA;
   logic          WR_VALID;
   logic          WR_READY;
   logic [DW-1:0] RD_DATA;
   logic          RD_VALID;
   logic          RD_READY;
   logic          BUSY;
   logic [AW-1:0] RAM_ADDRESS;
   logic [DW-1:0] RAM_DATA_IN;
   logic          RAM_OPCODE;
   logic [DW-1:0] RAM_DATA_OUT;

   ram_access_ctrl #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .LEN_W  (LW)
   ) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .REQ_VALID    (REQ_VALID),
      .REQ_READY    (REQ_READY),
      .REQ_WRITE    (REQ_WRITE),
      .REQ_ADDR     (REQ_ADDR),
      .REQ_LEN      (REQ_LEN),
      .WR_DATA      (WR_DATA),
      .WR_VALID     (WR_VALID),
      .WR_READY     (WR_READY),
      .RD_DATA      (RD_DATA),
      .RD_VALID     (RD_VALID),
      .RD_READY     (RD_READY),
      .BUSY         (BUSY),
      .RAM_ADDRESS  (RAM_ADDRESS),
      .RAM_DATA_IN  (RAM_DATA_IN),
      .RAM_OPCODE   (RAM_OPCODE),
      .RAM_DATA_OUT (RAM_DATA_OUT)
   );

   always #5 CLK = ~CLK;

   // Behavioural RAM: write on the strobe, combinational read.
   logic [DW-1:0] ram [16];
   always @(posedge CLK) begin
      if (RAM_OPCODE === 1'b1) ram[RAM_ADDRESS] <= RAM_DATA_IN;
   end
   assign RAM_DATA_OUT = ram[RAM_ADDRESS];

   // Bench-side model of RAM contents and scoreboards.
   logic [DW-1:0]    mem_model [16];
   logic [DW-1:0]    wdata [16];
   logic [AW+DW-1:0] exp_wr [$];
   logic [DW-1:0]    exp_rd [$];

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
   endtask

   // Write monitor: every strobe must match the oldest queued write, and a
   // strobe must never last longer than one cycle.
   logic prev_op = 1'b0;
   always @(negedge CLK) begin
      logic [AW+DW-1:0] e;
      if (RAM_OPCODE === 1'b1) begin
         check("wr_pending", 32'(exp_wr.size()), 32'd1);
         check("wr_single_cycle", 32'(prev_op), 32'd0);
         if (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            check("wr_addr", 32'(RAM_ADDRESS), 32'(e[AW+DW-1:DW]));
            check("wr_data", 32'(RAM_DATA_IN), 32'(e[DW-1:0]));
            $display("RAM write addr=%0d data=0x%02h", RAM_ADDRESS, RAM_DATA_IN);
         end
      end
      prev_op <= RAM_OPCODE;
   end

   // Issue one request and wait (bounded) for acceptance.
   task automatic request(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] len);
      REQ_VALID = 1'b1;
      REQ_WRITE = w;
      REQ_ADDR  = a;
      REQ_LEN   = len;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         if (REQ_READY === 1'b1) break;
      end
      check("req_ready", 32'(REQ_READY), 32'd1);
      @(posedge CLK);
      #1;
      REQ_VALID = 1'b0;
      $display("request %s addr=%0d len=%0d accepted", w ? "write" : "read", a, len);
   endtask

   // Drive len+1 write beats from wdata[], each preceded by 'delay' idle cycles.
   task automatic write_beats(input logic [AW-1:0] a, input int len, input int delay);
      for (int i = 0; i <= len; i++) begin
         logic [AW-1:0] ad;
         ad = a + AW'(i);
         for (int k = 0; k < delay; k++) begin
            @(negedge CLK);
            check("wr_wait_opcode", 32'(RAM_OPCODE), 32'd0);
            check("wr_wait_ready", 32'(WR_READY), 32'd1);
            check("busy_req_ready", 32'(REQ_READY), 32'd0);
            @(posedge CLK);
            #1;
         end
         exp_wr.push_back({ad, wdata[i]});
         mem_model[ad] = wdata[i];
         WR_VALID = 1'b1;
         WR_DATA  = wdata[i];
         @(negedge CLK);
         check("wr_ready", 32'(WR_READY), 32'd1);
         check("busy_req_ready", 32'(REQ_READY), 32'd0);
         @(posedge CLK);
         #1;
         WR_VALID = 1'b0;
         WR_DATA  = 8'hEE;
         @(negedge CLK);
         check("wr_pulse_opcode", 32'(RAM_OPCODE), 32'd1);
         check("wr_pulse_ready", 32'(WR_READY), 32'd0);
         check("busy_req_ready", 32'(REQ_READY), 32'd0);
         @(posedge CLK);
         #1;
      end
   endtask

   // Collect len+1 read beats; beat 'stall_beat' is back-pressured for
   // 'stall_cyc' cycles. Called right after the acceptance edge.
   task automatic read_beats(input logic [AW-1:0] a, input int len,
                             input int stall_beat, input int stall_cyc);
      for (int i = 0; i <= len; i++) exp_rd.push_back(mem_model[a + AW'(i)]);
      for (int i = 0; i <= len; i++) begin
         logic [AW-1:0] ad;
         ad = a + AW'(i);
         @(negedge CLK);
         check("rd_addr_valid", 32'(RD_VALID), 32'd0);
         check("rd_addr_opcode", 32'(RAM_OPCODE), 32'd0);
         check("rd_addr_address", 32'(RAM_ADDRESS), 32'(ad));
         @(negedge CLK);
         check("rd_resp_valid", 32'(RD_VALID), 32'd1);
         if (i == stall_beat) begin
            for (int k = 0; k < stall_cyc; k++) begin
               check("rd_hold_data", 32'(RD_DATA), 32'(exp_rd[0]));
               @(negedge CLK);
               check("rd_hold_valid", 32'(RD_VALID), 32'd1);
            end
         end
         check("rd_data", 32'(RD_DATA), 32'(exp_rd.pop_front()));
         $display("read beat %0d addr=%0d data=0x%02h", i, ad, RD_DATA);
         RD_READY = 1'b1;
         @(posedge CLK);
         #1;
         RD_READY = 1'b0;
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RESET = 1'b1; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = '0; REQ_LEN = '0;
      WR_DATA = '0; WR_VALID = 1'b0; RD_READY = 1'b0;
      for (int i = 0; i < 16; i++) mem_model[i] = '0;

      // Reset values.
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_opcode", 32'(RAM_OPCODE), 32'd0);
      check("rst_address", 32'(RAM_ADDRESS), 32'd0);
      check("rst_data_in", 32'(RAM_DATA_IN), 32'd0);
      check("rst_rd_data", 32'(RD_DATA), 32'd0);
      check("rst_rd_valid", 32'(RD_VALID), 32'd0);
      check("rst_wr_ready", 32'(WR_READY), 32'd0);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_req_ready", 32'(REQ_READY), 32'd1);
      @(posedge CLK);
      #1;
      RESET = 1'b0;

      // Fill all 16 words so later reads see known data.
      for (int i = 0; i < 16; i++) wdata[i] = 8'(8'h30 + i * 5);
      request(1'b1, 4'd0, 4'd15);
      write_beats(4'd0, 15, 0);
      @(negedge CLK); check("fill_idle", 32'(BUSY), 32'd0);
      @(posedge CLK); #1;

      // Single write then single read at address 3.
      wdata[0] = 8'hA5;
      request(1'b1, 4'd3, 4'd0);
      write_beats(4'd3, 0, 0);
      request(1'b0, 4'd3, 4'd0);
      read_beats(4'd3, 0, -1, 0);
      @(negedge CLK); check("single_idle", 32'(BUSY), 32'd0);
      @(posedge CLK); #1;

      // Wrapping 4-beat write from 14, read back.
      wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
      request(1'b1, 4'd14, 4'd3);
      write_beats(4'd14, 3, 0);
      request(1'b0, 4'd14, 4'd3);
      read_beats(4'd14, 3, -1, 0);
      @(negedge CLK); check("wrap_idle", 32'(BUSY), 32'd0);
      @(posedge CLK); #1;

      // 16-beat read with 5 cycles of back-pressure on beat 7.
      request(1'b0, 4'd0, 4'd15);
      read_beats(4'd0, 15, 7, 5);
      @(negedge CLK); check("long_read_idle", 32'(BUSY), 32'd0);
      @(posedge CLK); #1;

      // Slow write stream: 3 idle cycles before each beat.
      wdata[0] = 8'hC1; wdata[1] = 8'hC2; wdata[2] = 8'hC3;
      request(1'b1, 4'd6, 4'd2);
      write_beats(4'd6, 2, 3);
      request(1'b0, 4'd6, 4'd2);
      read_beats(4'd6, 2, -1, 0);
      @(posedge CLK); #1;

      // Reset while waiting for beat 2 of a 4-beat write.
      wdata[0] = 8'h5A;
      request(1'b1, 4'd8, 4'd3);
      write_beats(4'd8, 0, 0);
      RESET    = 1'b1;
      WR_VALID = 1'b1;
      WR_DATA  = 8'h77;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      RD_READY = 1'b1;
      @(negedge CLK);
      check("mid_rst_busy", 32'(BUSY), 32'd0);
      check("mid_rst_opcode", 32'(RAM_OPCODE), 32'd0);
      check("mid_rst_req_ready", 32'(REQ_READY), 32'd1);
      check("mid_rst_wr_ready", 32'(WR_READY), 32'd0);
      check("mid_rst_address", 32'(RAM_ADDRESS), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         check("mid_rst_stays_idle", 32'(BUSY), 32'd0);
      end
      WR_VALID = 1'b0;
      RD_READY = 1'b0;
      for (int i = 8; i < 12; i++) check("mid_rst_ram", 32'(ram[i]), 32'(mem_model[i]));
      $display("reset mid-burst: beats 2..4 discarded");
      @(posedge CLK); #1;

      // Request held valid across a write burst: accepted once, after the end.
      wdata[0] = 8'hD0; wdata[1] = 8'hD1;
      request(1'b1, 4'd5, 4'd1);
      REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 4'd5; REQ_LEN = 4'd1;
      write_beats(4'd5, 1, 0);
      @(negedge CLK);
      check("held_req_ready_after_last", 32'(REQ_READY), 32'd1);
      @(posedge CLK);
      #1;
      REQ_VALID = 1'b0;
      read_beats(4'd5, 1, -1, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         check("held_req_once", 32'(BUSY), 32'd0);
      end
      check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
      check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_ram_access_ctrl
